sipo_frame_ctrl: RTL
====================

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning frame length in bits (WIDTH >= 2).
REQ-002 SHALL have parameter FIRST_BIT_MSB, default 1: 1 = shift left so the first received bit ends in data_out[WIDTH-1]; 0 = shift right so the first bit ends in data_out[0].
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, frame-start request.
REQ-006 SHALL have port abort, input, 1, discards the partial frame.
REQ-007 SHALL have port bit_valid, input, 1, qualifies serial_in.
REQ-008 SHALL have port serial_in, input, 1, serial data bit.
REQ-009 SHALL have port busy, output, 1, high while a frame is being assembled.
REQ-010 SHALL have port bit_count, output, $clog2(WIDTH+1), number of bits accepted in the current frame.
REQ-011 SHALL have port data_out, output, WIDTH, held parallel frame.
REQ-012 SHALL have port data_valid, output, 1, data_out holds an unconsumed frame.
REQ-013 SHALL have port data_ready, input, 1, consumer accepts data_out.
REQ-014 SHALL have port overrun, output, 1, sticky flag: a completed frame was dropped.
REQ-015 SHALL have port clr_overrun, input, 1, clears overrun.

Function
REQ-016 SHALL implement an FSM with states IDLE and SHIFT, plus an output holding register with a valid/ready handshake that is independent of the FSM.
REQ-017 IDLE: start=1 -> SHIFT next edge; shift register and bit_count cleared on that edge; bit_valid ignored in IDLE and in the start cycle.
REQ-018 SHIFT: each edge with bit_valid=1 shifts serial_in in per FIRST_BIT_MSB and increments bit_count; bit_valid=0 holds all state, so gaps of any length are allowed.
REQ-019 The edge accepting bit WIDTH (bit_count = WIDTH-1 and bit_valid = 1) SHALL complete the frame: the assembled word goes to the holding register on that edge, and the FSM returns to IDLE with bit_count = 0.
REQ-020 After completion, data_valid SHALL be 1 and data_out the full word in the cycle after the last-bit edge (1-cycle latency).
REQ-021 Handshake: the frame is consumed on an edge where data_valid=1 and data_ready=1; data_valid drops next cycle unless a new frame loads on that same edge.
REQ-022 data_out SHALL be stable while data_valid=1 and not consumed.
REQ-023 Completion with data_valid=1 and data_ready=0: the new frame SHALL be discarded, data_out keeps the old frame, and overrun sets to 1.
REQ-024 Completion with data_valid=1 and data_ready=1 on the same edge: the old frame is consumed, the new frame loads, data_valid stays 1, and no overrun.
REQ-025 abort=1 in SHIFT SHALL return to IDLE next edge with bit_count = 0 and the partial frame lost; abort has priority over a simultaneous last bit; abort does not affect the holding register or overrun.
REQ-026 start=1 in SHIFT SHALL be ignored; abort and start both high in IDLE: abort wins and the FSM stays in IDLE.
REQ-027 busy = 1 exactly when the state is SHIFT.
REQ-028 clr_overrun=1 clears overrun next edge; if clr_overrun coincides with a new overrun event, overrun SHALL be 1 (set wins).

Reset
REQ-029 reset=0 SHALL immediately (asynchronously) force state IDLE, busy=0, bit_count=0, shift register=0, data_out=0, data_valid=0, overrun=0, including mid-frame.
REQ-030 Reset deassertion SHALL be taken synchronously; the first start is honoured on the first rising edge with reset=1.

Verification
REQ-031 Reset for 2 cycles, then start, then bits 1,1,0,0,1,1,0,1 on consecutive cycles with data_ready=0 -> data_out=8'b11001101 and data_valid=1 one cycle after bit 8; busy=0; bit_count=0.
REQ-032 Same frame with FIRST_BIT_MSB=0 -> data_out=8'b10110011.
REQ-033 Same frame with bit_valid low for 3 cycles between bits 4 and 5 -> identical result; bit_count holds at 4 during the gap.
REQ-034 Hold data_ready=0 and complete a second frame 8'hFF -> data_out stays 8'hCD and overrun=1; pulse clr_overrun -> overrun=0.
REQ-035 Frame A pending, and frame B's last bit coincides with data_ready=1 -> data_out=B, data_valid stays 1, overrun=0.
REQ-036 abort after 5 bits, or reset=0 after 5 bits -> busy=0 and bit_count=0 next edge (reset: immediately); the next full frame assembles correctly with no residue.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
// Serial-in / parallel-out frame assembler with start/abort control and a
// valid/ready output holding register that flags frames dropped while full.
module sipo_frame_ctrl #(
    parameter int WIDTH         = 8,
    parameter bit FIRST_BIT_MSB = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       bit_valid,
    input  logic                       serial_in,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_valid,
    input  logic                       data_ready,
    output logic                       overrun,
    input  logic                       clr_overrun
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_r;
    logic            busy_r;
    logic [CW-1:0]   bit_count_r;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] data_out_r;
    logic            data_valid_r;
    logic            overrun_r;

    logic [WIDTH-1:0] shifted_s;
    logic            last_bit_s;
    logic            load_s;
    logic            drop_s;

    // Next shift-register contents when a bit is accepted
    always_comb begin
        shifted_s = shift_r;
        if (FIRST_BIT_MSB) begin
            shifted_s = {shift_r[WIDTH-2:0], serial_in};
        end else begin
            shifted_s = {serial_in, shift_r[WIDTH-1:1]};
        end
    end

    // Abort outranks a coinciding last bit, so it also suppresses completion
    assign last_bit_s = (state_r == SHIFT) && !abort && bit_valid &&
                        (bit_count_r == CW'(WIDTH - 1));
    assign load_s     = last_bit_s && (!data_valid_r || data_ready);
    assign drop_s     = last_bit_s && data_valid_r && !data_ready;

    // Frame assembly FSM: shift register, bit counter and busy flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            bit_count_r <= {CW{1'b0}};
            shift_r     <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && !abort) begin
                        state_r     <= SHIFT;
                        busy_r      <= 1'b1;
                        bit_count_r <= {CW{1'b0}};
                        shift_r     <= {WIDTH{1'b0}};
                    end
                end
                SHIFT: begin
                    if (abort || last_bit_s) begin
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        bit_count_r <= {CW{1'b0}};
                        shift_r     <= {WIDTH{1'b0}};
                    end else if (bit_valid) begin
                        bit_count_r <= bit_count_r + CW'(1);
                        shift_r     <= shifted_s;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    bit_count_r <= {CW{1'b0}};
                    shift_r     <= {WIDTH{1'b0}};
                end
            endcase
        end
    end

    // Output holding register with valid/ready handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_r   <= {WIDTH{1'b0}};
            data_valid_r <= 1'b0;
        end else if (load_s) begin
            data_out_r   <= shifted_s;
            data_valid_r <= 1'b1;
        end else if (data_valid_r && data_ready) begin
            data_valid_r <= 1'b0;
        end
    end

    // Sticky overrun flag; a new drop outranks a simultaneous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (clr_overrun) begin
            overrun_r <= 1'b0;
        end
    end

    assign busy       = busy_r;
    assign bit_count  = bit_count_r;
    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign overrun    = overrun_r;

endmodule
